// File: rtl/mem_unit_pkg.sv
// rtl/mem_unit_pkg.sv - shared encodings, FSM states and offset-width helper for the sub-word memory unit
package mem_unit_pkg;

    // req_size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_WRITE   = 2'b10,
        ST_RESP    = 2'b11
    } state_t;

    // Number of byte-offset bits inside one memory word.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/subword_lane.sv
// rtl/subword_lane.sv - byte/half lane extract+extend for loads and lane merge for stores
//
// Ports:
//   word        memory word (read data)
//   offset      byte offset of the access inside the word
//   size        SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned 1 zero-extend, 0 sign-extend (loads)
//   wdata       right-justified store data
//   load_data   extracted and extended load value
//   merged      word with the selected lane(s) replaced by wdata
module subword_lane
    import mem_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    logic [OFF_W+2:0]  shamt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        load_data = shifted;
        lane_mask = '1;
        case (size)
            SZ_BYTE: begin
                load_data = {{(DATA_W-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
                lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
            end
            SZ_HALF: begin
                load_data = {{(DATA_W-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
                lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            end
            default: begin
                load_data = shifted;
                lane_mask = '1;
            end
        endcase
    end

    // Clear the target lanes, then OR in the right-justified store data moved to them.
    assign merged = (word & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);

endmodule

// File: rtl/subword_mem_unit.sv
// rtl/subword_mem_unit.sv - load/store unit with sub-word extract, RMW merge and misalignment flagging
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only when idle)
//   req_write/size/unsigned/addr/wdata   request fields
//   resp_valid             one-cycle completion pulse
//   resp_rdata/resp_err    response data / misaligned-or-illegal flag, held until next response
//   mem_addr/mem_wr/mem_wdata/mem_rdata  word-wide single-port memory interface
module subword_mem_unit
    import mem_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_write;
    logic [OFF_W-1:0]  r_offset;
    logic [DATA_W-1:0] r_wdata;

    logic              accept;
    logic              req_err;
    logic              rd_done;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    assign accept  = req_valid && (state == ST_IDLE);
    assign rd_done = (state == ST_RD_WAIT) && (cnt == CNT_W'(MEM_LAT - 1));

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[OFF_W-1:0];
            default: req_err = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nx = ST_RESP;
                    else if (req_write && (req_size == SZ_WORD))
                        state_nx = ST_WRITE;
                    else
                        state_nx = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rd_done)
                    state_nx = r_write ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_nx = ST_RESP;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        mem_wr     = (state == ST_WRITE);
    end

    // Request capture, latency counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_write    <= 1'b0;
            r_offset   <= '0;
            r_wdata    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt        <= '0;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_write    <= req_write;
                        r_offset   <= req_addr[OFF_W-1:0];
                        r_wdata    <= req_wdata;
                        mem_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        if (req_err) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (rd_done) begin
                        if (r_write) begin
                            mem_wdata <= merged;
                        end else begin
                            resp_rdata <= load_data;
                            resp_err   <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    subword_lane #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_lane (
        .word        (mem_rdata),
        .offset      (r_offset),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .load_data   (load_data),
        .merged      (merged)
    );

endmodule

// File: tb/tb_subword_mem_unit.sv
// tb/tb_subword_mem_unit.sv - directed table-driven bench for subword_mem_unit (MEM_LAT 1 and 3)
module tb_subword_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        va, vb;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_wr;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_wr;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] b_s1, b_s2;

    int          sel;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    subword_mem_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(va), .req_ready(a_req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(a_resp_valid),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_addr(a_mem_addr),
        .mem_wr(a_mem_wr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    subword_mem_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .req_valid(vb), .req_ready(b_req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_addr(b_mem_addr),
        .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memory models: latency 1 reads the array directly, latency 3 through two register stages.
    assign a_mem_rdata = mem_a[a_mem_addr[11:2]];
    always @(posedge clk) begin
        b_s1 <= mem_b[b_mem_addr[11:2]];
        b_s2 <= b_s1;
    end
    assign b_mem_rdata = b_s2;

    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_wr;
    logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
    assign o_req_ready  = (sel != 0) ? b_req_ready  : a_req_ready;
    assign o_resp_valid = (sel != 0) ? b_resp_valid : a_resp_valid;
    assign o_resp_err   = (sel != 0) ? b_resp_err   : a_resp_err;
    assign o_mem_wr     = (sel != 0) ? b_mem_wr     : a_mem_wr;
    assign o_resp_rdata = (sel != 0) ? b_resp_rdata : a_resp_rdata;
    assign o_mem_addr   = (sel != 0) ? b_mem_addr   : a_mem_addr;
    assign o_mem_wdata  = (sel != 0) ? b_mem_wdata  : a_mem_wdata;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] wdata_exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int lat);
        int          resp_k, wr_k, wr_cnt, exp_resp_k;
        logic [31:0] got_maddr, got_wdata, got_rdata;
        logic        got_err;
        resp_k = -1; wr_k = -1; wr_cnt = 0;
        got_maddr = '0; got_wdata = '0; got_rdata = '0; got_err = 1'b0;
        @(negedge clk);
        check({v.name, " ready"}, {31'd0, o_req_ready}, 32'd1);
        req_write = v.wr; req_size = v.sz; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        if (sel != 0) vb = 1'b1; else va = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0; vb = 1'b0;
        for (int k = 1; k <= 20 && resp_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) got_maddr = o_mem_addr;
            if (o_mem_wr) begin
                wr_cnt++;
                wr_k = k;
                got_wdata = o_mem_wdata;
                if (sel != 0) mem_b[o_mem_addr[11:2]] = o_mem_wdata;
                else          mem_a[o_mem_addr[11:2]] = o_mem_wdata;
            end
            if (o_resp_valid) begin
                resp_k = k;
                got_rdata = o_resp_rdata;
                got_err = o_resp_err;
            end
        end
        if (v.err)                        exp_resp_k = 1;
        else if (!v.wr)                   exp_resp_k = lat + 1;
        else if (v.sz == 2'b10)           exp_resp_k = 2;
        else                              exp_resp_k = lat + 2;
        check({v.name, " resp_cycle"}, resp_k, exp_resp_k);
        check({v.name, " resp_err"}, {31'd0, got_err}, {31'd0, v.err});
        check({v.name, " resp_rdata"}, got_rdata, v.rdata);
        check({v.name, " wr_count"}, wr_cnt, (v.wr && !v.err) ? 1 : 0);
        if (!v.err) check({v.name, " mem_addr"}, got_maddr, {v.addr[31:2], 2'b00});
        if (v.wr && !v.err) begin
            check({v.name, " wr_cycle"}, wr_k, exp_resp_k - 1);
            check({v.name, " mem_wdata"}, got_wdata, v.wdata_exp);
        end
    endtask

    initial begin
        int          np, na;
        int          rk [2];
        int          ak [2];
        logic [31:0] rd [2];
        logic        acc, seen_wr, seen_resp;

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[32'h100 >> 2] = 32'h80FF1234; mem_b[32'h100 >> 2] = 32'h80FF1234;
        mem_a[32'h200 >> 2] = 32'h11223344;
        mem_a[32'h300 >> 2] = 32'hDEADBEEF;
        mem_a[32'h400 >> 2] = 32'h1234F00D; mem_b[32'h400 >> 2] = 32'h1234F00D;
        mem_a[32'h500 >> 2] = 32'hA1B2C3D4;

        //          name      wr    sz     uns   addr        wdata         err   rdata         wdata_exp
        vecs[0]  = '{"lb_s",   1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        1'b0, 32'hFFFFFF80, 32'h0};
        vecs[1]  = '{"sh",     1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 1'b0, 32'h0,        32'hABCD3344};
        vecs[2]  = '{"sw_mis", 1'b1, 2'b10, 1'b0, 32'h301, 32'h12345678, 1'b1, 32'h0,        32'h0};
        vecs[3]  = '{"lw",     1'b0, 2'b10, 1'b0, 32'h300, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{"lhu",    1'b0, 2'b01, 1'b1, 32'h400, 32'h0,        1'b0, 32'h0000F00D, 32'h0};
        vecs[5]  = '{"lh",     1'b0, 2'b01, 1'b0, 32'h400, 32'h0,        1'b0, 32'hFFFFF00D, 32'h0};
        vecs[6]  = '{"lbu1",   1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        1'b0, 32'h00000012, 32'h0};
        vecs[7]  = '{"lb2",    1'b0, 2'b00, 1'b0, 32'h102, 32'h0,        1'b0, 32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{"sb1",    1'b1, 2'b00, 1'b0, 32'h501, 32'hFFFFFF77, 1'b0, 32'h0,        32'hA1B277D4};
        vecs[9]  = '{"lw_sb",  1'b0, 2'b10, 1'b0, 32'h500, 32'h0,        1'b0, 32'hA1B277D4, 32'h0};
        vecs[10] = '{"sw",     1'b1, 2'b10, 1'b0, 32'h500, 32'hCAFEF00D, 1'b0, 32'h0,        32'hCAFEF00D};
        vecs[11] = '{"lw_sw",  1'b0, 2'b10, 1'b0, 32'h500, 32'h0,        1'b0, 32'hCAFEF00D, 32'h0};
        vecs[12] = '{"sz11",   1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0,        32'h0};
        vecs[13] = '{"lh_mis", 1'b0, 2'b01, 1'b0, 32'h401, 32'h0,        1'b1, 32'h0,        32'h0};
        vecs[14] = '{"sh_lo",  1'b1, 2'b01, 1'b0, 32'h200, 32'h00005555, 1'b0, 32'h0,        32'hABCD5555};
        vecs[15] = '{"lhu_hi", 1'b0, 2'b01, 1'b1, 32'h202, 32'h0,        1'b0, 32'h0000ABCD, 32'h0};

        sel = 0; va = 1'b0; vb = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst ready",      {31'd0, a_req_ready},  32'd1);
        check("rst resp_valid", {31'd0, a_resp_valid}, 32'd0);
        check("rst resp_rdata", a_resp_rdata,          32'd0);
        check("rst resp_err",   {31'd0, a_resp_err},   32'd0);
        check("rst mem_wr",     {31'd0, a_mem_wr},     32'd0);
        check("rst mem_addr",   a_mem_addr,            32'd0);
        check("rst mem_wdata",  a_mem_wdata,           32'd0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], 1);

        // Latency 3 instance
        sel = 1;
        run_vec('{"l3_lhu", 1'b0, 2'b01, 1'b1, 32'h400, 32'h0,  1'b0, 32'h0000F00D, 32'h0}, 3);
        run_vec('{"l3_lh",  1'b0, 2'b01, 1'b0, 32'h400, 32'h0,  1'b0, 32'hFFFFF00D, 32'h0}, 3);
        run_vec('{"l3_sb",  1'b1, 2'b00, 1'b0, 32'h100, 32'h5A, 1'b0, 32'h0,        32'h80FF125A}, 3);
        run_vec('{"l3_lw",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0,  1'b0, 32'h80FF125A, 32'h0}, 3);
        sel = 0;

        // Reset during RD_WAIT of a byte store
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h301; req_wdata = 32'h11;
        va = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0;
        seen_wr = 1'b0; seen_resp = 1'b0;
        @(negedge clk);
        seen_wr |= a_mem_wr; seen_resp |= a_resp_valid;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort ready",      {31'd0, a_req_ready}, 32'd1);
        check("abort resp_rdata", a_resp_rdata,         32'd0);
        check("abort resp_err",   {31'd0, a_resp_err},  32'd0);
        check("abort mem_addr",   a_mem_addr,           32'd0);
        check("abort mem_wdata",  a_mem_wdata,          32'd0);
        for (int k = 0; k < 4; k++) begin
            seen_wr |= a_mem_wr; seen_resp |= a_resp_valid;
            @(negedge clk);
        end
        check("abort no_mem_wr",   {31'd0, seen_wr},   32'd0);
        check("abort no_resp",     {31'd0, seen_resp}, 32'd0);
        check("abort mem_intact",  mem_a[32'h300 >> 2], 32'hDEADBEEF);

        // req_valid held high across two back-to-back requests
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h300; req_wdata = '0;
        va = 1'b1;
        np = 0; na = 0;
        rk[0] = -1; rk[1] = -1; ak[0] = -1; ak[1] = -1; rd[0] = '0; rd[1] = '0;
        for (int k = 0; k < 10; k++) begin
            if (a_resp_valid) begin
                if (np < 2) begin rd[np] = a_resp_rdata; rk[np] = k; end
                np++;
            end
            acc = a_req_ready && va;
            if (acc) begin
                if (na < 2) ak[na] = k;
                na++;
            end
            @(posedge clk);
            #1;
            if (acc && na == 1) req_addr = 32'h100;
            if (acc && na == 2) va = 1'b0;
            @(negedge clk);
        end
        check("b2b accepts",     na,    2);
        check("b2b responses",   np,    2);
        check("b2b accept2_cyc", ak[1], 3);
        check("b2b resp1_cyc",   rk[0], 2);
        check("b2b resp2_cyc",   rk[1], 5);
        check("b2b resp1_data",  rd[0], 32'hDEADBEEF);
        check("b2b resp2_data",  rd[1], 32'h80FF1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
